regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (enable, RW, PW) between two writeback requesters:
  - A: ALU writeback
  - B: memory/load writeback
- Each requester uses a valid/ready handshake; grants are round-robin.
- One registered commit stage drives the register file.
- Also exports a forwarding view and a pending-write busy mask so readers can resolve in-flight writes.

---
 rtl/regfile_write_arbiter.sv | 111 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters (A = ALU writeback, B = memory/load writeback). Each requester
// uses a valid/ready handshake, and contention is resolved round-robin. An
// accepted write passes through one registered commit stage that drives the
// register file write port. That same stage is also exported as a forwarding
// view and as a one-hot busy mask.
//
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   stall                1 = accept no new requests this cycle
//   a_valid/a_rd/a_data  requester A write request
//   a_ready              requester A accepted this cycle
//   b_valid/b_rd/b_data  requester B write request
//   b_ready              requester B accepted this cycle
//   rf_enable/rf_rw/rf_pw  register file write port
//   fwd_valid/fwd_rd/fwd_data  forwarding view of the commit stage
//   busy                 one-hot mask of the register being committed
//   commit_cnt           number of writes actually issued (wraps)
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     a_valid,
  input  logic [ADDR_W-1:0]        a_rd,
  input  logic [DATA_W-1:0]        a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDR_W-1:0]        b_rd,
  input  logic [DATA_W-1:0]        b_data,
  output logic                     b_ready,
  output logic                     rf_enable,
  output logic [ADDR_W-1:0]        rf_rw,
  output logic [DATA_W-1:0]        rf_pw,
  output logic                     fwd_valid,
  output logic [ADDR_W-1:0]        fwd_rd,
  output logic [DATA_W-1:0]        fwd_data,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [CNT_W-1:0]         commit_cnt
);

  // 1 = B won the most recent transfer, so A wins the next contention.
  logic              last_grant_b;
  logic              stage_en;
  logic              a_xfer;
  logic              b_xfer;
  logic              xfer;
  logic [ADDR_W-1:0] xfer_rd;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_live;

  // Round-robin grant. A requester that is alone always wins, and with both
  // valid the one that did not win last time gets the port.
  assign a_ready = ~reset & ~stall & a_valid & (~b_valid | last_grant_b);
  assign b_ready = ~reset & ~stall & b_valid & (~a_valid | ~last_grant_b);

  assign a_xfer    = a_valid & a_ready;
  assign b_xfer    = b_valid & b_ready;
  assign xfer      = a_xfer | b_xfer;
  assign xfer_rd   = a_xfer ? a_rd : b_rd;
  assign xfer_data = a_xfer ? a_data : b_data;

  // A write to register 0 completes its handshake but is dropped here,
  // so it never reaches the stage.
  assign xfer_live = xfer & (xfer_rd != '0);

  // Commit stage plus arbitration state. The stage drains every cycle.
  // rf_rw and rf_pw are loaded only by real writes, so they hold their last
  // value while the port is idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_b <= 1'b1;
      stage_en     <= 1'b0;
      rf_rw        <= '0;
      rf_pw        <= '0;
      commit_cnt   <= '0;
    end else begin
      if (xfer) begin
        last_grant_b <= b_xfer;
      end
      stage_en <= xfer_live;
      if (xfer_live) begin
        rf_rw <= xfer_rd;
        rf_pw <= xfer_data;
      end
      if (stage_en) begin
        commit_cnt <= commit_cnt + CNT_W'(1);
      end
    end
  end

  // The enable is gated by reset so a write still sitting in the stage when
  // reset arrives never reaches the register file.
  assign rf_enable = stage_en & ~reset;
  assign fwd_valid = rf_enable;
  assign fwd_rd    = rf_rw;
  assign fwd_data  = rf_pw;

  always_comb begin
    busy = '0;
    if (rf_enable) begin
      busy[rf_rw] = 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. A reference arbiter model
// predicts the readies and pushes each expected commit into a scoreboard
// queue. A negedge monitor pops those entries and compares them against the
// register file port, the forwarding view, busy and commit_cnt. A behavioural
// register file driven by the write port is used for the final value checks.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  logic              clock;
  logic              reset;
  logic              stall;
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rf_enable;
  logic [ADDR_W-1:0] rf_rw;
  logic [DATA_W-1:0] rf_pw;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [31:0]       busy;
  logic [CNT_W-1:0]  commit_cnt;

  regfile_write_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .a_valid   (a_valid),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .rf_enable (rf_enable),
    .rf_rw     (rf_rw),
    .rf_pw     (rf_pw),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .busy      (busy),
    .commit_cnt(commit_cnt)
  );

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vectors;
  int          n_miscompares;
  int          cycle;
  logic        model_lg_b;
  int          exp_cnt;
  logic [31:0] rf_model [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cycle);
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic av,
                                input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                                input logic bv, input logic [ADDR_W-1:0] brd,
                                input logic [DATA_W-1:0] bd);
    stall   = st;
    a_valid = av;
    a_rd    = ard;
    a_data  = ad;
    b_valid = bv;
    b_rd    = brd;
    b_data  = bd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Behavioural register file fed by the DUT write port.
  always @(posedge clock) begin
    if (rf_enable) rf_model[rf_rw] <= rf_pw;
  end

  // Cycle counter and synchronous reset of the reference model state.
  always @(posedge clock) begin
    cycle = cycle + 1;
    if (reset) begin
      model_lg_b = 1'b1;
      exp_cnt    = 0;
      sb_q.delete();
    end
  end

  // Monitor: commit checks against the scoreboard, then ready prediction.
  always @(negedge clock) begin
    logic exp_en;
    logic exp_a, exp_b;
    if (reset) begin
      check_output("rst_a_ready", a_ready, 0);
      check_output("rst_b_ready", b_ready, 0);
      check_output("rst_rf_enable", rf_enable, 0);
      check_output("rst_fwd_valid", fwd_valid, 0);
      check_output("rst_busy", busy, 0);
      sb_q.delete();
    end else begin
      while (sb_q.size() > 0 && sb_q[0].due < cycle) begin
        check_output("commit_late", cycle, sb_q[0].due);
        void'(sb_q.pop_front());
      end
      exp_en = (sb_q.size() > 0) && (sb_q[0].due == cycle);
      check_output("rf_enable", rf_enable, exp_en);
      check_output("fwd_valid", fwd_valid, exp_en);
      check_output("busy", busy, exp_en ? (32'd1 << sb_q[0].rd) : 32'd0);
      check_output("commit_cnt", commit_cnt, exp_cnt);
      if (exp_en) begin
        check_output("rf_rw", rf_rw, sb_q[0].rd);
        check_output("rf_pw", rf_pw, sb_q[0].data);
        check_output("fwd_rd", fwd_rd, sb_q[0].rd);
        check_output("fwd_data", fwd_data, sb_q[0].data);
        void'(sb_q.pop_front());
        exp_cnt++;
      end
      exp_a = !stall && a_valid && (!b_valid || model_lg_b);
      exp_b = !stall && b_valid && (!a_valid || !model_lg_b);
      check_output("a_ready", a_ready, exp_a);
      check_output("b_ready", b_ready, exp_b);
      if (exp_a) begin
        model_lg_b = 1'b0;
        if (a_rd != 0) sb_q.push_back('{due: cycle + 1, rd: a_rd, data: a_data});
      end else if (exp_b) begin
        model_lg_b = 1'b1;
        if (b_rd != 0) sb_q.push_back('{due: cycle + 1, rd: b_rd, data: b_data});
      end
    end
  end

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    cycle         = 0;
    model_lg_b    = 1'b1;
    exp_cnt       = 0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    reset   = 1'b1;
    stall   = 1'b0;
    a_valid = 1'b0;
    a_rd    = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_rd    = '0;
    b_data  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check_output("rst_rf_rw", rf_rw, 0);
    check_output("rst_rf_pw", rf_pw, 0);
    check_output("rst_commit_cnt", commit_cnt, 0);

    $display("[TB] single write");
    apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    idle(2);
    check_output("single_cnt", commit_cnt, 1);

    $display("[TB] contention round-robin");
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 1'b1, 5'(1 + i), 32'hA000 + 32'(i),
                     1'b1, 5'(10 + i), 32'hB000 + 32'(i));
    idle(2);
    check_output("contention_cnt", commit_cnt, 5);

    $display("[TB] same destination race");
    apply_stimulus(1'b0, 1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'd2);
    idle(2);

    $display("[TB] index zero");
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    idle(2);
    check_output("zero_cnt", commit_cnt, 7);

    $display("[TB] stall");
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 32'h33);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    apply_stimulus(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd6, 32'h66);
    idle(2);
    check_output("stall_cnt", commit_cnt, 10);

    $display("[TB] reset mid-flight");
    apply_stimulus(1'b0, 1'b1, 5'd9, 32'h99999999, 1'b0, '0, '0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_output("midrst_cnt", commit_cnt, 0);
    check_output("midrst_rf_rw", rf_rw, 0);
    check_output("midrst_rf_pw", rf_pw, 0);
    apply_stimulus(1'b0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd13, 32'hC2);
    apply_stimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd13, 32'hC2);
    idle(2);
    check_output("post_rst_cnt", commit_cnt, 2);

    check_output("reg5", rf_model[5], 32'hDEADBEEF);
    check_output("reg7", rf_model[7], 32'd2);
    check_output("reg0", rf_model[0], 32'd0);
    check_output("reg9", rf_model[9], 32'd0);
    check_output("reg4", rf_model[4], 32'h44);
    check_output("reg6", rf_model[6], 32'h66);
    check_output("reg13", rf_model[13], 32'hC2);
    check_output("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
